// File: rtl/cop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cop_pkg
// Description : Shared definitions for the CP0 unit and the exception
//               controller: CP0 command encodings, controller state
//               enumeration, default exception vector and the event
//               priority selector.
// Revision    : 1.0 - initial release
// ============================================================================
package cop_pkg;

    // CP0 command encodings (shared with cop)
    localparam logic [2:0] COP_NOP     = 3'd0;
    localparam logic [2:0] COP_SYSCALL = 3'd1;
    localparam logic [2:0] COP_BREAK   = 3'd2;
    localparam logic [2:0] COP_ERET    = 3'd3;
    localparam logic [2:0] COP_INT     = 3'd4;
    localparam logic [2:0] COP_OVF     = 3'd5;

    // Default redirect target for exceptions and interrupts
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

    // Exception controller sequencing states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_REDIRECT = 2'd3
    } exc_state_e;

    // Fixed priority: ovf > syscall > break > eret > interrupt.
    // Returns COP_NOP when nothing is requested.
    function automatic logic [2:0] exc_select(
        input logic ovf,
        input logic syscall,
        input logic brk,
        input logic eret,
        input logic int_take
    );
        logic [2:0] op;
        op = COP_NOP;
        if (ovf)           op = COP_OVF;
        else if (syscall)  op = COP_SYSCALL;
        else if (brk)      op = COP_BREAK;
        else if (eret)     op = COP_ERET;
        else if (int_take) op = COP_INT;
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync
// Description : Per-bit two-flop synchronizer for asynchronous interrupt
//               lines. Both stages clear on synchronous active-low reset.
//               Used by exc_ctrl only when EXC_IRQ_SYNC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] irq_i,
    output logic [WIDTH-1:0] irq_s_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage shift: first stage may go metastable, second is clean.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= irq_i;
            sync_q <= meta_q;
        end
    end

    assign irq_s_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl
// Description : Exception/interrupt controller in front of CP0. Samples the
//               EX-stage exception flags and masked interrupt lines, picks
//               one event by fixed priority and sequences a CP0 command,
//               a pipeline flush and a PC redirect (vector, or EPC for ERET).
//               Optional feature macro: EXC_IRQ_SYNC_EN (2-flop irq
//               synchronizer in front of the interrupt logic).
// Revision    : 1.0 - initial release
// ============================================================================
module exc_ctrl
    import cop_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        stall_in,
    input  logic        ex_ovf,
    input  logic        ex_syscall,
    input  logic        ex_break,
    input  logic        ex_eret,
    input  logic [19:0] ex_code,
    input  logic [31:0] ex_pc,
    input  logic [5:0]  irq,
    input  logic [5:0]  irq_mask,
    input  logic        ie,
    input  logic        exl,
    input  logic [31:0] epc,
    output logic [2:0]  cop_op,
    output logic [19:0] code,
    output logic [31:0] next_pc,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    // COMMIT already provides one flush cycle; FLUSH covers the remainder.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit         SKIP_FLUSH = (FLUSH_CYCLES == 1);

    logic [5:0]  irq_s;

    exc_state_e  state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [2:0]  kind_q,  kind_d;
    logic [19:0] code_q,  code_d;
    logic [31:0] pc_q,    pc_d;

    logic        sample;
    logic        sync_flag;
    logic        irq_take;
    logic [2:0]  ev_op;

`ifdef EXC_IRQ_SYNC_EN
    irq_sync #(
        .WIDTH   (6)
    ) u_irq_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_i   (irq),
        .irq_s_o (irq_s)
    );
`else
    // Lines are already synchronous to clk.
    assign irq_s = irq;
`endif

    // Event selection; interrupts only ride on a real, unstalled instruction
    // without any synchronous exception of its own.
    assign sample    = (state_q == ST_IDLE) && ex_valid && !stall_in;
    assign sync_flag = ex_ovf || ex_syscall || ex_break || ex_eret;
    assign irq_take  = !sync_flag && ie && !exl && ((irq_s & irq_mask) != 6'd0);
    assign ev_op     = exc_select(ex_ovf, ex_syscall, ex_break, ex_eret, irq_take);

    // Next-state, capture and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        kind_d      = kind_q;
        code_d      = code_q;
        pc_d        = pc_q;
        cop_op      = COP_NOP;
        code        = 20'd0;
        next_pc     = 32'd0;
        flush       = 1'b0;
        pc_redirect = 1'b0;
        redirect_pc = 32'd0;
        busy        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sample && (ev_op != COP_NOP)) begin
                    kind_d  = ev_op;
                    code_d  = ((ev_op == COP_SYSCALL) || (ev_op == COP_BREAK)) ? ex_code : 20'd0;
                    pc_d    = ex_pc;
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                cop_op  = kind_q;
                code    = code_q;
                next_pc = pc_q;
                flush   = 1'b1;
                busy    = 1'b1;
                if (SKIP_FLUSH) begin
                    state_d = ST_REDIRECT;
                end else begin
                    cnt_d   = FLUSH_LOAD;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                busy  = 1'b1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_REDIRECT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_REDIRECT: begin
                pc_redirect = 1'b1;
                busy        = 1'b1;
                redirect_pc = (kind_q == COP_ERET) ? epc : EXC_VECTOR;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, flush counter and captured event registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            kind_q  <= COP_NOP;
            code_q  <= 20'd0;
            pc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
            code_q  <= code_d;
            pc_q    <= pc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exc_ctrl
// Description : Self-checking bench for exc_ctrl. A timeline model predicts
//               every output each cycle; directed scenarios add literal
//               expectations for the key cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_ctrl;
    import cop_pkg::*;

    localparam int          F   = 2;
    localparam logic [31:0] VEC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid, stall_in, ex_ovf, ex_syscall, ex_break, ex_eret;
    logic [19:0] ex_code;
    logic [31:0] ex_pc;
    logic [5:0]  irq, irq_mask;
    logic        ie, exl;
    logic [31:0] epc;
    logic [2:0]  cop_op;
    logic [19:0] code;
    logic [31:0] next_pc;
    logic        flush, pc_redirect, busy;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    exc_ctrl #(
        .EXC_VECTOR   (VEC),
        .FLUSH_CYCLES (F)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .stall_in    (stall_in),
        .ex_ovf      (ex_ovf),
        .ex_syscall  (ex_syscall),
        .ex_break    (ex_break),
        .ex_eret     (ex_eret),
        .ex_code     (ex_code),
        .ex_pc       (ex_pc),
        .irq         (irq),
        .irq_mask    (irq_mask),
        .ie          (ie),
        .exl         (exl),
        .epc         (epc),
        .cop_op      (cop_op),
        .code        (code),
        .next_pc     (next_pc),
        .flush       (flush),
        .pc_redirect (pc_redirect),
        .redirect_pc (redirect_pc),
        .busy        (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model: position in the event timeline ----------------
    // ph = cycles elapsed since the sampling edge (0 = idle).
    int          ph = 0;
    logic [2:0]  m_kind = 3'd0;
    logic [19:0] m_code = 20'd0;
    logic [31:0] m_pc   = 32'd0;
`ifdef EXC_IRQ_SYNC_EN
    logic [5:0]  irq_d1 = 6'd0;
    logic [5:0]  irq_d2 = 6'd0;
`endif

    always @(posedge clk) begin
        logic [5:0] irq_eff;
        logic [2:0] k;
`ifdef EXC_IRQ_SYNC_EN
        irq_eff = irq_d2;
`else
        irq_eff = irq;
`endif
        if (!rst_n) begin
            ph = 0;
`ifdef EXC_IRQ_SYNC_EN
            irq_d1 = 6'd0;
            irq_d2 = 6'd0;
`endif
        end else begin
            if (ph == 0) begin
                if (ex_valid && !stall_in) begin
                    if (ex_ovf)                                       k = 3'd5;
                    else if (ex_syscall)                              k = 3'd1;
                    else if (ex_break)                                k = 3'd2;
                    else if (ex_eret)                                 k = 3'd3;
                    else if (ie && !exl && ((irq_eff & irq_mask) != 0)) k = 3'd4;
                    else                                              k = 3'd0;
                    if (k != 3'd0) begin
                        ph     = 1;
                        m_kind = k;
                        m_code = (k == 3'd1 || k == 3'd2) ? ex_code : 20'd0;
                        m_pc   = ex_pc;
                    end
                end
            end else if (ph == F + 1) begin
                ph = 0;
            end else begin
                ph = ph + 1;
            end
`ifdef EXC_IRQ_SYNC_EN
            irq_d2 = irq_d1;
            irq_d1 = irq;
`endif
        end
        started = 1'b1;
    end

    // ---------------- per-cycle compare against the model -----------------
    always @(negedge clk) begin
        if (started) begin
            chk("busy",        32'(busy),        32'(ph != 0));
            chk("cop_op",      32'(cop_op),      (ph == 1) ? 32'(m_kind) : 32'd0);
            chk("code",        32'(code),        (ph == 1) ? 32'(m_code) : 32'd0);
            chk("next_pc",     next_pc,          (ph == 1) ? m_pc : 32'd0);
            chk("flush",       32'(flush),       32'(ph >= 1 && ph <= F));
            chk("pc_redirect", 32'(pc_redirect), 32'(ph == F + 1));
            chk("redirect_pc", redirect_pc,
                (ph == F + 1) ? ((m_kind == 3'd3) ? epc : VEC) : 32'd0);
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic clear_inputs();
        ex_valid   = 1'b0;
        stall_in   = 1'b0;
        ex_ovf     = 1'b0;
        ex_syscall = 1'b0;
        ex_break   = 1'b0;
        ex_eret    = 1'b0;
        ex_code    = 20'd0;
        ex_pc      = 32'd0;
        irq        = 6'd0;
        irq_mask   = 6'd0;
        ie         = 1'b0;
        exl        = 1'b0;
    endtask

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic count_window(input int n, output int red, output int com, output int bsy);
        red = 0;
        com = 0;
        bsy = 0;
        repeat (n) begin
            @(negedge clk);
            if (pc_redirect === 1'b1) red++;
            if (cop_op !== 3'd0)      com++;
            if (busy !== 1'b0)        bsy++;
        end
    endtask

    int red, com, bsy, found;

    initial begin
        clear_inputs();
        epc = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_cop_op", 32'(cop_op), 32'd0);

        // SYSCALL
        next_drive();
        ex_valid = 1'b1; ex_syscall = 1'b1; ex_code = 20'h00ABC; ex_pc = 32'h0000_1000;
        next_drive();
        clear_inputs();
        @(negedge clk);
        chk("sys_cop_op",  32'(cop_op), 32'd1);
        chk("sys_code",    32'(code),   32'h00ABC);
        chk("sys_next_pc", next_pc,     32'h0000_1000);
        chk("sys_flush",   32'(flush),  32'd1);
        @(negedge clk);
        chk("sys_flush2",  32'(flush),  32'd1);
        @(negedge clk);
        chk("sys_redirect",    32'(pc_redirect), 32'd1);
        chk("sys_redirect_pc", redirect_pc,      32'h0000_0080);
        @(negedge clk);
        chk("sys_busy_fall", 32'(busy), 32'd0);

        // priority: ovf wins, code forced to zero, one sequence only
        next_drive();
        ex_valid = 1'b1; ex_ovf = 1'b1; ex_syscall = 1'b1; ex_break = 1'b1;
        ex_code = 20'h12345; ex_pc = 32'h0000_2000;
        next_drive();
        clear_inputs();
        @(negedge clk);
        chk("pri_cop_op", 32'(cop_op), 32'd5);
        chk("pri_code",   32'(code),   32'd0);
        count_window(7, red, com, bsy);
        chk("pri_one_redirect", 32'(red), 32'd1);

        // ERET returns to EPC
        next_drive();
        ex_valid = 1'b1; ex_eret = 1'b1; ex_pc = 32'h0000_3000; epc = 32'h0000_2004;
        next_drive();
        clear_inputs();
        @(negedge clk);
        chk("eret_cop_op", 32'(cop_op), 32'd3);
        @(negedge clk);
        @(negedge clk);
        chk("eret_redirect",    32'(pc_redirect), 32'd1);
        chk("eret_redirect_pc", redirect_pc,      32'h0000_2004);
        @(negedge clk);

        // interrupt blocked by EXL, then taken once EXL clears
        next_drive();
        ex_valid = 1'b1; irq = 6'b000100; irq_mask = 6'b000100; ie = 1'b1; exl = 1'b1;
        count_window(6, red, com, bsy);
        chk("irq_exl_blocked", 32'(bsy), 32'd0);
        next_drive();
        exl = 1'b0;
        found = 0;
        for (int i = 0; i < 6 && found == 0; i++) begin
            @(negedge clk);
            if (cop_op === 3'd4) found = 1;
        end
        chk("irq_taken", 32'(found), 32'd1);
        next_drive();
        clear_inputs();
        repeat (6) @(negedge clk);

        // interrupt with mask zero is never taken
        next_drive();
        ex_valid = 1'b1; irq = 6'b000100; irq_mask = 6'b000000; ie = 1'b1; exl = 1'b0;
        count_window(8, red, com, bsy);
        chk("irq_masked", 32'(bsy), 32'd0);
        next_drive();
        clear_inputs();

        // BREAK during FLUSH is ignored
        next_drive();
        ex_valid = 1'b1; ex_syscall = 1'b1; ex_code = 20'h00011; ex_pc = 32'h0000_4000;
        next_drive();
        clear_inputs();
        @(negedge clk);
        next_drive();
        ex_valid = 1'b1; ex_break = 1'b1; ex_code = 20'h00022; ex_pc = 32'h0000_4004;
        next_drive();
        clear_inputs();
        count_window(8, red, com, bsy);
        chk("busy_ignore_redirects", 32'(red), 32'd1);
        chk("busy_ignore_commits",   32'(com), 32'd0);

        // stall holds off sampling
        next_drive();
        ex_valid = 1'b1; ex_syscall = 1'b1; stall_in = 1'b1; ex_code = 20'h00033; ex_pc = 32'h0000_5000;
        count_window(4, red, com, bsy);
        chk("stall_no_action", 32'(bsy), 32'd0);
        next_drive();
        stall_in = 1'b0;
        next_drive();
        clear_inputs();
        @(negedge clk);
        chk("stall_release_cop_op", 32'(cop_op), 32'd1);
        repeat (4) @(negedge clk);

        // reset in the middle of FLUSH aborts the sequence
        next_drive();
        ex_valid = 1'b1; ex_ovf = 1'b1; ex_pc = 32'h0000_6000;
        next_drive();
        clear_inputs();
        @(negedge clk);
        chk("rstmid_cop_op", 32'(cop_op), 32'd5);
        next_drive();
        rst_n = 1'b0;
        next_drive();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_busy",        32'(busy),        32'd0);
        chk("rstmid_flush",       32'(flush),       32'd0);
        chk("rstmid_cop_op0",     32'(cop_op),      32'd0);
        chk("rstmid_redirect_pc", redirect_pc,      32'd0);
        count_window(6, red, com, bsy);
        chk("rstmid_no_redirect", 32'(red), 32'd0);

        // back-to-back: new sample on first IDLE cycle after REDIRECT
        next_drive();
        ex_valid = 1'b1; ex_syscall = 1'b1; ex_code = 20'h00044; ex_pc = 32'h0000_7000;
        next_drive();
        count_window(8, red, com, bsy);
        chk("b2b_commits",   32'(com), 32'd2);
        chk("b2b_redirects", 32'(red), 32'd2);
        next_drive();
        clear_inputs();
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
